// File: rtl/register_readback_pkg.sv
// Shared definitions for the register read-back responder: default widths,
// the FSM state encoding and the value returned for unmapped reads.
package register_readback_pkg;

  localparam int          ADRSIZE_DEF = 8;
  localparam int          REGSIZE_DEF = 32;
  localparam logic [31:0] ERRDATA_DEF = 32'hDEADBEEF;

  // Read pipeline states; the encoding is also exported on dbg_state.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MATCH = 2'd1,
    MUX   = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/register_readback_addr_match.sv
// Registered one-hot address comparator: compares the captured read address
// against every slice of the address map and holds the hit vector for the
// following pipeline stage.
module readback_addr_match #(
  parameter int                         ADRSIZE = 8,
  parameter int                         NREGS   = 16,
  parameter logic [NREGS*ADRSIZE-1:0]   REGMAP  = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_en,
  input  logic [ADRSIZE-1:0] i_adr,
  output logic [NREGS-1:0]   o_hit
);

  logic [NREGS-1:0] w_hit;
  logic [NREGS-1:0] r_hit;

  // One comparator per map entry; duplicates may set several bits.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NREGS; i++) begin
      w_hit[i] = (i_adr == REGMAP[i*ADRSIZE +: ADRSIZE]);
    end
  end

  // Capture the hit vector only in the match stage so it stays stable after.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_hit <= '0;
    end else if (i_en) begin
      r_hit <= w_hit;
    end
  end

  assign o_hit = r_hit;

endmodule

// File: rtl/register_readback.sv
// Read-side responder for the register bank.
//
// Handshake: a read is requested by holding rd=1 (with adr) for a rising edge
// while rd_busy=0; the request is then accepted and exactly one rd_valid pulse
// follows four edges later carrying data_rd and rd_err. rd=1 while rd_busy=1
// is discarded (no queueing) and counted in the saturating drop_count.
// adr is ignored whenever rd=0. rd_err is only ever high together with
// rd_valid; data_rd keeps its last response value between pulses.
module register_readback
  import register_readback_pkg::*;
#(
  parameter int                          ADRSIZE = ADRSIZE_DEF,
  parameter int                          REGSIZE = REGSIZE_DEF,
  parameter int                          NREGS   = 16,
  parameter logic [NREGS*ADRSIZE-1:0]    REGMAP  = '0,
  parameter logic [REGSIZE-1:0]          ERRDATA = REGSIZE'(ERRDATA_DEF)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      rd,
  input  logic [ADRSIZE-1:0]        adr,
  input  logic [NREGS*REGSIZE-1:0]  regs_flat,
  output logic [REGSIZE-1:0]        data_rd,
  output logic                      rd_valid,
  output logic                      rd_err,
  output logic                      rd_busy,
  output logic [7:0]                drop_count,
  output logic [1:0]                dbg_state
);

  state_e               r_state;
  logic [ADRSIZE-1:0]   r_adr_q;
  logic [REGSIZE-1:0]   r_data_q;
  logic                 r_err_q;
  logic [REGSIZE-1:0]   r_data_rd;
  logic                 r_rd_valid;
  logic                 r_rd_err;
  logic [7:0]           r_drop_count;

  logic [NREGS-1:0]     w_hit;
  logic                 w_any;
  logic [REGSIZE-1:0]   w_sel_data;

  readback_addr_match #(
    .ADRSIZE (ADRSIZE),
    .NREGS   (NREGS),
    .REGMAP  (REGMAP)
  ) u_match (
    .clock (clock),
    .reset (reset),
    .i_en  (r_state == MATCH),
    .i_adr (r_adr_q),
    .o_hit (w_hit)
  );

  // Priority select: scanning downward lets the lowest set hit bit win.
  always_comb begin
    w_any      = 1'b0;
    w_sel_data = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_any      = 1'b1;
        w_sel_data = regs_flat[i*REGSIZE +: REGSIZE];
      end
    end
  end

  // Read FSM with registered response outputs and the drop counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_adr_q      <= '0;
      r_data_q     <= '0;
      r_err_q      <= 1'b0;
      r_data_rd    <= '0;
      r_rd_valid   <= 1'b0;
      r_rd_err     <= 1'b0;
      r_drop_count <= 8'd0;
    end else begin
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;

      if (rd && (r_state != IDLE) && (r_drop_count != 8'hFF)) begin
        r_drop_count <= r_drop_count + 8'd1;
      end

      case (r_state)
        IDLE: begin
          if (rd) begin
            r_adr_q <= adr;
            r_state <= MATCH;
          end
        end
        MATCH: begin
          r_state <= MUX;
        end
        MUX: begin
          // regs_flat is sampled here; later writes do not alter the response.
          if (w_any) begin
            r_data_q <= w_sel_data;
            r_err_q  <= 1'b0;
          end else begin
            r_data_q <= ERRDATA;
            r_err_q  <= 1'b1;
          end
          r_state <= RESP;
        end
        RESP: begin
          r_rd_valid <= 1'b1;
          r_rd_err   <= r_err_q;
          r_data_rd  <= r_data_q;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_rd    = r_data_rd;
  assign rd_valid   = r_rd_valid;
  assign rd_err     = r_rd_err;
  assign rd_busy    = (r_state != IDLE);
  assign drop_count = r_drop_count;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_register_readback.sv
// Bench for register_readback: directed scenarios plus random traffic, with a
// queue-based scoreboard fed at issue time and drained by a response monitor.
module tb_register_readback;

  localparam int ADRSIZE = 8;
  localparam int REGSIZE = 32;
  localparam int NREGS   = 16;

  // Address map: entry i lives at 8'h10+i, except entries 2 and 5 share 8'h22.
  function automatic logic [7:0] map_addr(int i);
    if (i == 2 || i == 5) return 8'h22;
    return 8'(8'h10 + i);
  endfunction

  function automatic logic [NREGS*ADRSIZE-1:0] build_map();
    logic [NREGS*ADRSIZE-1:0] m;
    m = '0;
    for (int i = 0; i < NREGS; i++) m[i*ADRSIZE +: ADRSIZE] = map_addr(i);
    return m;
  endfunction

  localparam logic [NREGS*ADRSIZE-1:0] MAP = build_map();

  logic                      clock;
  logic                      reset;
  logic                      rd;
  logic [ADRSIZE-1:0]        adr;
  logic [NREGS*REGSIZE-1:0]  regs_flat;
  logic [REGSIZE-1:0]        data_rd;
  logic                      rd_valid;
  logic                      rd_err;
  logic                      rd_busy;
  logic [7:0]                drop_count;
  logic [1:0]                dbg_state;

  logic [REGSIZE-1:0]        regs [NREGS];

  register_readback #(
    .ADRSIZE (ADRSIZE),
    .REGSIZE (REGSIZE),
    .NREGS   (NREGS),
    .REGMAP  (MAP),
    .ERRDATA (32'hDEADBEEF)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rd         (rd),
    .adr        (adr),
    .regs_flat  (regs_flat),
    .data_rd    (data_rd),
    .rd_valid   (rd_valid),
    .rd_err     (rd_err),
    .rd_busy    (rd_busy),
    .drop_count (drop_count),
    .dbg_state  (dbg_state)
  );

  // Clock and register-bank packing
  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NREGS; i++) regs_flat[i*REGSIZE +: REGSIZE] = regs[i];
  end

  // Scoreboard state and reference model
  logic [REGSIZE:0] exp_q [$];
  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;
  int m_busy   = 0;    // edges remaining before the responder accepts again
  int m_drops  = 0;

  // Lowest-indexed matching entry answers; no match returns the error word.
  function automatic logic [REGSIZE:0] ref_read(logic [7:0] a);
    for (int i = 0; i < NREGS; i++) begin
      if (map_addr(i) == a) return {1'b0, regs[i]};
    end
    return {1'b1, 32'hDEADBEEF};
  endfunction

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Driver: present inputs for one rising edge, update the model, return at
  // the following falling edge. One read is accepted per four edges.
  task automatic cycle(input logic r, input logic [7:0] a);
    rd  = r;
    adr = a;
    if (r) begin
      if (m_busy == 0) begin
        exp_q.push_back(ref_read(a));
        m_busy = 3;
      end else begin
        m_busy--;
        if (m_drops < 255) m_drops++;
      end
    end else if (m_busy > 0) begin
      m_busy--;
    end
    @(negedge clock);
  endtask

  function automatic logic [7:0] rand_adr();
    case ($urandom_range(0, 3))
      0:       return 8'(8'h10 + $urandom_range(0, 15));
      1:       return 8'h22;
      2:       return 8'($urandom_range(0, 255));
      default: return 8'h7F;
    endcase
  endfunction

  // Monitor: every response pulse is matched against the oldest expectation.
  always @(negedge clock) begin
    if (!reset) begin
      n_checks++;
      if (rd_err && !rd_valid) begin
        n_errors++;
        $display("FAIL err_without_valid: got rd_err=1 expected 0");
      end
      if (rd_valid) begin
        n_valid++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_valid: got data=%0h err=%0b expected no response", data_rd, rd_err);
        end else begin
          logic [REGSIZE:0] e;
          e = exp_q.pop_front();
          if ({rd_err, data_rd} !== e) begin
            n_errors++;
            $display("FAIL response: got err=%0b data=%0h expected err=%0b data=%0h",
                     rd_err, data_rd, e[REGSIZE], e[REGSIZE-1:0]);
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    int v0;
    reset = 1'b1;
    rd    = 1'b0;
    adr   = '0;
    for (int i = 0; i < NREGS; i++) regs[i] = 32'hA000_0000 + i;
    repeat (3) @(negedge clock);

    check("rst_valid", 64'(rd_valid), 64'd0);
    check("rst_err",   64'(rd_err),   64'd0);
    check("rst_busy",  64'(rd_busy),  64'd0);
    check("rst_data",  64'(data_rd),  64'd0);
    check("rst_drops", 64'(drop_count), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    reset = 1'b0;

    // Mapped read and its latency
    cycle(1'b1, 8'h13);
    check("busy_after_accept", 64'(rd_busy), 64'd1);
    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);
    check("no_early_valid", 64'(rd_valid), 64'd0);
    check("busy_in_resp",   64'(rd_busy),  64'd1);
    cycle(1'b0, 8'h00);
    check("lat_valid", 64'(rd_valid), 64'd1);
    check("lat_data",  64'(data_rd),  64'hA000_0003);
    check("lat_err",   64'(rd_err),   64'd0);
    check("idle_with_valid", 64'(rd_busy), 64'd0);
    cycle(1'b0, 8'h00);
    check("valid_one_cycle", 64'(rd_valid), 64'd0);
    check("data_holds",      64'(data_rd),  64'hA000_0003);

    // Unmapped read
    cycle(1'b1, 8'h7F);
    repeat (3) cycle(1'b0, 8'h00);
    check("unmapped_err",  64'(rd_err),  64'd1);
    check("unmapped_data", 64'(data_rd), 64'hDEAD_BEEF);
    repeat (2) cycle(1'b0, 8'h00);

    // rd held high for eight edges: two accepted, six dropped
    v0 = n_valid;
    repeat (8) cycle(1'b1, 8'h10);
    rd = 1'b0;
    repeat (6) cycle(1'b0, 8'h00);
    check("held_pulses", 64'(n_valid - v0), 64'd2);
    check("held_drops",  64'(drop_count),   64'd6);
    check("held_data",   64'(data_rd),      64'hA000_0000);

    // Duplicate map entries: lowest index answers
    cycle(1'b1, 8'h22);
    repeat (5) cycle(1'b0, 8'h00);
    check("dup_data", 64'(data_rd), 64'hA000_0002);

    // Write before the sampling edge is visible; write after it is not
    cycle(1'b1, 8'h14);
    regs[4] = 32'h1234_5678;
    exp_q[exp_q.size()-1] = {1'b0, 32'h1234_5678};
    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);
    regs[4] = 32'h0BAD_0BAD;
    repeat (3) cycle(1'b0, 8'h00);
    check("late_write_hidden", 64'(data_rd), 64'h1234_5678);

    // Reset while in the mux stage abandons the read
    cycle(1'b1, 8'h13);
    cycle(1'b0, 8'h00);
    check("in_mux_state", 64'(dbg_state), 64'd2);
    reset = 1'b1;
    void'(exp_q.pop_back());
    m_busy  = 0;
    m_drops = 0;
    cycle(1'b0, 8'h00);
    check("mid_rst_valid", 64'(rd_valid),   64'd0);
    check("mid_rst_data",  64'(data_rd),    64'd0);
    check("mid_rst_busy",  64'(rd_busy),    64'd0);
    check("mid_rst_drops", 64'(drop_count), 64'd0);
    check("mid_rst_state", 64'(dbg_state),  64'd0);
    reset = 1'b0;
    v0 = n_valid;
    repeat (4) cycle(1'b0, 8'h00);
    check("abandoned_no_valid", 64'(n_valid - v0), 64'd0);
    cycle(1'b1, 8'h11);
    repeat (5) cycle(1'b0, 8'h00);
    check("post_rst_read", 64'(n_valid - v0), 64'd1);

    // Random traffic with occasional register updates while idle
    for (int k = 0; k < 400; k++) begin
      if (m_busy == 0 && $urandom_range(0, 3) == 0) begin
        regs[$urandom_range(0, NREGS-1)] = $urandom;
      end
      cycle(($urandom_range(0, 2) == 0), rand_adr());
    end
    repeat (6) cycle(1'b0, 8'h00);
    check("rand_drops", 64'(drop_count), 64'(m_drops));

    // Drop counter saturation
    for (int k = 0; k < 300; k++) cycle(1'b1, rand_adr());
    check("sat_drops", 64'(drop_count), 64'hFF);
    for (int k = 0; k < 20; k++) cycle(1'b1, rand_adr());
    check("sat_hold", 64'(drop_count), 64'hFF);
    repeat (6) cycle(1'b0, 8'h00);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
